io_nibble_scheduler: RTL
========================

// Module: io_nibble_scheduler
// PURPOSE
//   Shares the design's 4-bit nibble input port between two byte-wide requesters.
//   - Grants one requester at a time and splits its byte into two nibbles.
//   - Drives the din/valid/toggle inputs of the design.
//   - Waits a fixed settle time, samples the 8-bit dout and returns it tagged with the requester id.
//   - Sits between host-side logic and the design under test.
// PARAMETERS
//   RESP_WAIT  2  cycles between the high-nibble beat and the dout sample (0..15)
// PORTS
//   clk          in   1  single clock, rising edge
//   reset_n      in   1  reset, asynchronous, active-low
//   req0_valid   in   1  requester 0 has a byte
//   req0_ready   out  1  requester 0 byte accepted this cycle
//   req0_data    in   8  requester 0 byte
//   req0_toggle  in   1  toggle level to present with requester 0 byte
//   req1_valid   in   1  requester 1 has a byte
//   req1_ready   out  1  requester 1 byte accepted this cycle
//   req1_data    in   8  requester 1 byte
//   req1_toggle  in   1  toggle level to present with requester 1 byte
//   rsp_valid    out  1  response available
//   rsp_ready    in   1  response consumer accepts
//   rsp_id       out  1  requester that owns the response
//   rsp_data     out  8  sampled dout
//   dut_din      out  4  nibble to design
//   dut_valid    out  1  nibble strobe to design
//   dut_toggle   out  1  toggle to design
//   dut_dout     in   8  design output
//   busy         out  1  high in any state other than IDLE
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE, last_grant=1, all outputs 0.
//     A transaction in flight when reset asserts is dropped silently.
//   - States: IDLE -> LO -> HI -> WAIT -> RESP -> IDLE. WAIT is skipped when RESP_WAIT=0.
//   - IDLE:
//     - reqN_ready = grant==N && reqN_valid. Ready is combinational from valid and registered state.
//     - On accept, capture data/toggle/id, update last_grant, go to LO.
//   - Arbitration, both valid: grant the requester != last_grant (round robin).
//     One valid: grant it.
//   - LO (1 cycle): dut_din=data[3:0], dut_valid=1, dut_toggle=captured toggle.
//   - HI (1 cycle): dut_din=data[7:4], dut_valid=1, dut_toggle=captured toggle.
//   - WAIT: counter loads RESP_WAIT-1 and decrements. Leave at 0.
//   - Sample point: dut_dout is registered into rsp_data on the edge leaving WAIT,
//     or leaving HI if RESP_WAIT=0.
//   - Outside LO/HI, dut_din=0, dut_valid=0 and dut_toggle=0.
//   - RESP: rsp_valid=1 with stable rsp_id/rsp_data until rsp_valid&&rsp_ready, then IDLE.
//     - No grants while in RESP. Requester valids are held off (ready=0).
//   - Latency: accept at cycle T; LO at T+1, HI at T+2, rsp_valid first high at T+3+RESP_WAIT.
//     Minimum issue interval per byte is 4+RESP_WAIT cycles with rsp_ready tied high.
//   - rsp_data is the full 8-bit dout. No width conversion.
//   - Widths: the RESP_WAIT counter is 4 bits. RESP_WAIT>15 is illegal.
// CONFIGURATION
//   SCHED_STRICT_PRIO_EN
//   - Defined: requester 0 always wins when both are valid. last_grant is still
//     updated but ignored.
//   - Undefined (default): round robin as above.
// TESTING
//   1. reset_n=0 mid-HI with req0 active -> all outputs 0 immediately.
//      After release, IDLE, busy=0, no response.
//   2. req0 data=8'hA5, toggle=1, RESP_WAIT=2 ->
//      - T+1: din=5, valid=1, toggle=1.
//      - T+2: din=A, valid=1, toggle=1.
//      - T+5: rsp_valid=1, rsp_id=0.
//   3. dut_dout driven 8'h3C only in the sample cycle -> rsp_data=8'h3C.
//      rsp_data is held while rsp_ready=0 for 5 cycles.
//   4. Both requesters valid continuously, rsp_ready=1 -> grants 0,1,0,1.
//      With SCHED_STRICT_PRIO_EN: 0,0,0,0.
//   5. RESP_WAIT=0, req1 data=8'hFF -> rsp_valid at T+3, rsp_id=1.
//      No WAIT state is entered.
//   6. rsp_ready=0 while req1_valid=1 -> req1_ready stays 0 until the response
//      is taken; the next grant occurs the cycle after.

Source files
------------

// File: rtl/io_nibble_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// io_nibble_scheduler
//
// Shares a 4-bit nibble input port of a downstream design between two
// byte-wide requesters. One requester is granted at a time. Its byte is sent
// as two nibble beats, low nibble first. After a fixed settle time the 8-bit
// design output is sampled and returned, tagged with the requester id.
//
// Parameters
//   RESP_WAIT   cycles between the high-nibble beat and the dout sample (0..15)
//
// Configuration macro
//   SCHED_STRICT_PRIO_EN  defined  : requester 0 always wins a tie
//                         undefined: round robin on ties (default)
//
// Ports
//   clk, reset_n                      clock (rising edge), async active-low reset
//   req0_valid/ready/data/toggle      requester 0 byte handshake
//   req1_valid/ready/data/toggle      requester 1 byte handshake
//   rsp_valid/ready/id/data           response handshake (sampled dout + owner)
//   dut_din/valid/toggle              nibble drive towards the design
//   dut_dout                          design output, sampled once per byte
//   busy                              high whenever not idle
// -----------------------------------------------------------------------------
module io_nibble_scheduler #(
  parameter int unsigned RESP_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data,
  input  logic       req0_toggle,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_toggle,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic [3:0] dut_din,
  output logic       dut_valid,
  output logic       dut_toggle,
  input  logic [7:0] dut_dout,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4
  } state_e;

  // The wait counter counts down to zero, so it is loaded one short.
  localparam logic [3:0] WAIT_LOAD = (RESP_WAIT == 0) ? 4'd0 : 4'(RESP_WAIT - 1);

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       id_q, id_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       tog_q, tog_d;

  logic       in_idle;
  logic       both_valid;
  logic       any_valid;
  logic       grant;
  logic       tie_grant;

  assign in_idle    = (state_q == S_IDLE);
  assign both_valid = req0_valid & req1_valid;
  assign any_valid  = req0_valid | req1_valid;

`ifdef SCHED_STRICT_PRIO_EN
  assign tie_grant = 1'b0;
`else
  assign tie_grant = ~last_grant_q;
`endif

  // With a single valid requester the grant simply follows it; with none the
  // value is unused.
  assign grant = both_valid ? tie_grant : ~req0_valid;

  // Ready is gated by reset_n so nothing is acknowledged while reset is held.
  assign req0_ready = reset_n & in_idle & req0_valid & ~grant;
  assign req1_ready = reset_n & in_idle & req1_valid &  grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    rsp_data_d   = rsp_data_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    tog_d        = tog_q;
    dut_din      = 4'd0;
    dut_valid    = 1'b0;
    dut_toggle   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          id_d         = grant;
          last_grant_d = grant;
          data_d       = grant ? req1_data   : req0_data;
          tog_d        = grant ? req1_toggle : req0_toggle;
          state_d      = S_LO;
        end
      end
      S_LO: begin
        dut_din    = data_q[3:0];
        dut_valid  = 1'b1;
        dut_toggle = tog_q;
        state_d    = S_HI;
      end
      S_HI: begin
        dut_din    = data_q[7:4];
        dut_valid  = 1'b1;
        dut_toggle = tog_q;
        if (RESP_WAIT == 0) begin
          rsp_data_d = dut_dout;
          state_d    = S_RESP;
        end else begin
          cnt_d   = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d = dut_dout;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      rsp_data_q   <= 8'd0;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      rsp_data_q   <= rsp_data_d;
      cnt_q        <= cnt_d;
    end
  end

  // Captured byte and toggle are only consumed after a fresh accept, so they
  // carry no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tog_q  <= tog_d;
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = ~in_idle;

endmodule
